// File: rtl/audio_sample_packet_decoder.sv
// -----------------------------------------------------------------------------
// audio_sample_packet_decoder
//
// Sink-side decoder for HDMI Audio Sample Packets (2-channel layout only).
// One packet per packet_valid strobe: recovers the L/R sample words and the
// per-channel V/U bits, checks IEC 60958 even parity, tracks the 192-frame
// block position from the B flag and assembles both 192-bit channel status
// blocks from the C bits. Subpackets 1-3 are not used.
//
// Ports
//   packet_clk        in   1    sole clock, rising edge
//   reset_n           in   1    asynchronous active-low reset
//   packet_valid      in   1    strobe: header/sub0 hold one packet
//   header            in   16   [12]=layout [8]=sample_present[0] [4]=B [0]=flat
//   sub0              in   56   [55:32]=ch0 word [31:8]=ch1 word
//                               [7:4]={P1,C1,U1,V1} [3:0]={P0,C0,U0,V0}
//   sample_valid      out  1    pulse: new sample pair on outputs
//   sample_l/_r       out  24   channel 0 / channel 1 word (0 when flat)
//   valid_bit         out  2    {V1,V0} of last accepted frame
//   user_bit          out  2    {U1,U0} of last accepted frame
//   parity_error      out  2    per-channel parity fail, qualified by sample_valid
//   frame_index       out  8    block index of last accepted frame (0 when unlocked)
//   locked            out  1    block framing synchronised
//   sync_error        out  1    pulse on framing loss / early block start
//   unsupported       out  1    pulse: packet dropped because layout=1
//   channel_status_l  out  192  completed ch0 status block, bit k = C0 of frame k
//   channel_status_r  out  192  completed ch1 status block, bit k = C1 of frame k
//   cs_valid          out  1    pulse: channel_status_l/r updated
// -----------------------------------------------------------------------------
module audio_sample_packet_decoder #(
  parameter bit CS_REQUIRE_MATCH = 1'b1
) (
  input  logic         packet_clk,
  input  logic         reset_n,
  input  logic         packet_valid,
  input  logic [15:0]  header,
  input  logic [55:0]  sub0,
  output logic         sample_valid,
  output logic [23:0]  sample_l,
  output logic [23:0]  sample_r,
  output logic [1:0]   valid_bit,
  output logic [1:0]   user_bit,
  output logic [1:0]   parity_error,
  output logic [7:0]   frame_index,
  output logic         locked,
  output logic         sync_error,
  output logic         unsupported,
  output logic [191:0] channel_status_l,
  output logic [191:0] channel_status_r,
  output logic         cs_valid
);

  localparam logic [7:0]   LAST_IDX    = 8'd191;
  // Channel-number field of the status block; allowed to differ between L and R.
  localparam logic [191:0] CH_NUM_MASK = {168'd0, 4'hF, 20'd0};

  typedef enum logic {
    UNSYNC = 1'b0,
    SYNC   = 1'b1
  } state_t;

  state_t state, state_next;

  // Field extraction
  logic        layout, present, b_flag, flat;
  logic [23:0] word0, word1;
  logic        v0, u0, c0, p0, v1, u1, c1, p1;
  logic        accept;
  logic        unused_hdr;

  assign layout  = header[12];
  assign present = header[8];
  assign b_flag  = header[4];
  assign flat    = header[0];
  assign word0   = sub0[55:32];
  assign word1   = sub0[31:8];
  assign {p1, c1, u1, v1} = sub0[7:4];
  assign {p0, c0, u0, v0} = sub0[3:0];
  assign unused_hdr = ^{header[15:13], header[11:9], header[7:5], header[3:1]};

  assign accept = packet_valid & ~layout & present;

  // Framing control
  logic [7:0]   idx_next;
  logic         store;
  logic         sync_err;
  logic [191:0] shadow_l, shadow_r;
  logic [191:0] shadow_l_next, shadow_r_next;
  logic         cs_match, cs_update;

  // NOTE: every output of this block is given a default before any branch, so
  // no path leaves a signal unassigned and no latch can be inferred.
  always_comb begin
    state_next = state;
    idx_next   = frame_index;
    store      = 1'b0;
    sync_err   = 1'b0;
    if (accept) begin
      unique case (state)
        UNSYNC: begin
          // Frames seen before the first B are discarded; index stays 0.
          if (b_flag) begin
            state_next = SYNC;
            idx_next   = 8'd0;
            store      = 1'b1;
          end
        end
        SYNC: begin
          if (frame_index == LAST_IDX) begin
            // The block must wrap exactly here; a missing B means lost framing.
            idx_next = 8'd0;
            if (b_flag) begin
              store = 1'b1;
            end else begin
              state_next = UNSYNC;
              sync_err   = 1'b1;
            end
          end else if (b_flag) begin
            // Early block start: resynchronise on the new B.
            idx_next = 8'd0;
            store    = 1'b1;
            sync_err = 1'b1;
          end else begin
            idx_next = frame_index + 8'd1;
            store    = 1'b1;
          end
        end
        default: state_next = UNSYNC;
      endcase
    end
  end

  always_comb begin
    shadow_l_next = shadow_l;
    shadow_r_next = shadow_r;
    if (store) begin
      shadow_l_next[idx_next] = c0;
      shadow_r_next[idx_next] = c1;
    end
  end

  assign cs_match  = ((shadow_l_next ^ shadow_r_next) & ~CH_NUM_MASK) == '0;
  // The block completes with the frame that stores index 191, so the
  // published value includes that frame's own C bits.
  assign cs_update = store && (idx_next == LAST_IDX) && (!CS_REQUIRE_MATCH || cs_match);

  // State register
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge packet_clk or negedge reset_n) begin
    if (!reset_n) state <= UNSYNC;
    else          state <= state_next;
  end

  assign locked = (state == SYNC);

  // Datapath and per-frame outputs
  // NOTE: the shadow status registers are reset along with everything else so
  // a block assembled after reset never carries bits from before it.
  always_ff @(posedge packet_clk or negedge reset_n) begin
    if (!reset_n) begin
      sample_valid     <= 1'b0;
      sample_l         <= '0;
      sample_r         <= '0;
      valid_bit        <= '0;
      user_bit         <= '0;
      parity_error     <= '0;
      frame_index      <= '0;
      sync_error       <= 1'b0;
      unsupported      <= 1'b0;
      cs_valid         <= 1'b0;
      shadow_l         <= '0;
      shadow_r         <= '0;
      channel_status_l <= '0;
      channel_status_r <= '0;
    end else begin
      sample_valid <= accept;
      unsupported  <= packet_valid & layout;
      sync_error   <= sync_err;
      cs_valid     <= cs_update;
      frame_index  <= idx_next;
      shadow_l     <= shadow_l_next;
      shadow_r     <= shadow_r_next;
      if (accept) begin
        valid_bit <= {v1, v0};
        user_bit  <= {u1, u0};
        if (flat) begin
          sample_l     <= '0;
          sample_r     <= '0;
          parity_error <= '0;
        end else begin
          sample_l     <= word0;
          sample_r     <= word1;
          parity_error <= {^{word1, v1, u1, c1, p1}, ^{word0, v0, u0, c0, p0}};
        end
      end
      if (cs_update) begin
        channel_status_l <= shadow_l_next;
        channel_status_r <= shadow_r_next;
      end
    end
  end

endmodule

// File: tb/tb_audio_sample_packet_decoder.sv
// -----------------------------------------------------------------------------
// tb_audio_sample_packet_decoder
//
// Drives directed and randomised audio sample packets into the decoder and
// compares every output against a behavioural model of the packet rules
// (integer block position, bit-array status blocks, popcount parity).
// -----------------------------------------------------------------------------
module tb_audio_sample_packet_decoder;

  logic         packet_clk;
  logic         reset_n;
  logic         packet_valid;
  logic [15:0]  header;
  logic [55:0]  sub0;
  logic         sample_valid;
  logic [23:0]  sample_l, sample_r;
  logic [1:0]   valid_bit, user_bit, parity_error;
  logic [7:0]   frame_index;
  logic         locked, sync_error, unsupported, cs_valid;
  logic [191:0] channel_status_l, channel_status_r;

  audio_sample_packet_decoder #(.CS_REQUIRE_MATCH(1'b1)) dut (
    .packet_clk       (packet_clk),
    .reset_n          (reset_n),
    .packet_valid     (packet_valid),
    .header           (header),
    .sub0             (sub0),
    .sample_valid     (sample_valid),
    .sample_l         (sample_l),
    .sample_r         (sample_r),
    .valid_bit        (valid_bit),
    .user_bit         (user_bit),
    .parity_error     (parity_error),
    .frame_index      (frame_index),
    .locked           (locked),
    .sync_error       (sync_error),
    .unsupported      (unsupported),
    .channel_status_l (channel_status_l),
    .channel_status_r (channel_status_r),
    .cs_valid         (cs_valid)
  );

  initial begin
    packet_clk = 1'b0;
    forever #5 packet_clk = ~packet_clk;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cs_cnt   = 0;

  // Model state
  bit           m_locked;
  int           m_pos;
  logic [191:0] m_sh_l, m_sh_r;

  // Expected outputs
  logic         e_sv, e_unsup, e_sync, e_csv;
  logic [23:0]  e_sl, e_sr;
  logic [1:0]   e_par, e_v, e_u;
  logic [191:0] e_csl, e_csr;

  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_locked = 1'b0; m_pos = 0; m_sh_l = '0; m_sh_r = '0;
    e_sv = 0; e_unsup = 0; e_sync = 0; e_csv = 0;
    e_sl = '0; e_sr = '0; e_par = '0; e_v = '0; e_u = '0;
    e_csl = '0; e_csr = '0;
  endtask

  function automatic logic [15:0] mk_hdr(input bit layout, input bit present,
                                         input bit b, input bit flat);
    return {3'b000, layout, 3'b000, present, 3'b000, b, 3'b000, flat};
  endfunction

  // vuc = {C,U,V}; parity generated correct, then optionally inverted.
  function automatic logic [55:0] mk_sub(input logic [23:0] w0, input logic [23:0] w1,
                                         input logic [2:0] vuc0, input logic [2:0] vuc1,
                                         input bit perr0, input bit perr1);
    logic p0, p1;
    p0 = (($countones({w0, vuc0}) % 2) == 1) ^ perr0;
    p1 = (($countones({w1, vuc1}) % 2) == 1) ^ perr1;
    return {w0, w1, p1, vuc1, p0, vuc0};
  endfunction

  task automatic model_step(input logic [15:0] hdr, input logic [55:0] sb);
    bit stored, same;
    int np;
    e_sv = 0; e_sync = 0; e_csv = 0;
    e_unsup = hdr[12];
    if (!hdr[12] && hdr[8]) begin
      e_sv = 1;
      e_v  = {sb[4], sb[0]};
      e_u  = {sb[5], sb[1]};
      if (hdr[0]) begin
        e_sl = '0; e_sr = '0; e_par = '0;
      end else begin
        e_sl = sb[55:32];
        e_sr = sb[31:8];
        e_par[0] = ($countones({sb[55:32], sb[3:0]}) % 2) == 1;
        e_par[1] = ($countones({sb[31:8], sb[7:4]}) % 2) == 1;
      end
      stored = 0;
      if (!m_locked) begin
        if (hdr[4]) begin m_locked = 1; m_pos = 0; stored = 1; end
      end else begin
        np = m_pos + 1;
        if (np == 192) begin
          m_pos = 0;
          if (hdr[4]) stored = 1;
          else begin m_locked = 0; e_sync = 1; end
        end else if (hdr[4]) begin
          m_pos = 0; e_sync = 1; stored = 1;
        end else begin
          m_pos = np; stored = 1;
        end
      end
      if (stored) begin
        m_sh_l[m_pos] = sb[2];
        m_sh_r[m_pos] = sb[6];
        if (m_pos == 191) begin
          same = 1;
          for (int k = 0; k < 192; k++)
            if ((k < 20 || k > 23) && m_sh_l[k] != m_sh_r[k]) same = 0;
          if (same) begin
            e_csv = 1; e_csl = m_sh_l; e_csr = m_sh_r;
          end
        end
      end
    end
  endtask

  task automatic check_all(input string ph);
    check({ph, ".sample_valid"}, 192'(sample_valid), 192'(e_sv));
    check({ph, ".unsupported"},  192'(unsupported),  192'(e_unsup));
    check({ph, ".sync_error"},   192'(sync_error),   192'(e_sync));
    check({ph, ".cs_valid"},     192'(cs_valid),     192'(e_csv));
    check({ph, ".locked"},       192'(locked),       192'(m_locked));
    check({ph, ".frame_index"},  192'(frame_index),  192'(m_pos));
    check({ph, ".sample_l"},     192'(sample_l),     192'(e_sl));
    check({ph, ".sample_r"},     192'(sample_r),     192'(e_sr));
    check({ph, ".parity_error"}, 192'(parity_error), 192'(e_par));
    check({ph, ".valid_bit"},    192'(valid_bit),    192'(e_v));
    check({ph, ".user_bit"},     192'(user_bit),     192'(e_u));
    check({ph, ".cs_l"},         channel_status_l,   e_csl);
    check({ph, ".cs_r"},         channel_status_r,   e_csr);
  endtask

  // One packet: verify idle hold, strobe for one cycle, verify the result
  // on the following falling edge with junk driven on the idle bus.
  task automatic send(input logic [15:0] hdr, input logic [55:0] sb);
    @(negedge packet_clk);
    e_sv = 0; e_unsup = 0; e_sync = 0; e_csv = 0;
    check_all("idle");
    packet_valid = 1'b1; header = hdr; sub0 = sb;
    @(negedge packet_clk);
    packet_valid = 1'b0;
    header = 16'($urandom());
    sub0   = 56'({$urandom(), $urandom()});
    model_step(hdr, sb);
    check_all("pkt");
    if (cs_valid) cs_cnt++;
  endtask

  task automatic do_reset();
    @(negedge packet_clk);
    #2 reset_n = 1'b0;
    #1 model_reset();
    check_all("reset");
    @(negedge packet_clk);
    reset_n = 1'b1;
  endtask

  function automatic logic [2:0] rnd_vu(input logic c);
    logic [1:0] r;
    r = 2'($urandom());
    return {c, r};
  endfunction

  logic [7:0]   pat;
  logic [191:0] pat_block;
  logic [23:0]  w0, w1;
  logic         c0, c1, b;
  int           np;

  initial begin
    reset_n = 1'b0; packet_valid = 1'b0; header = '0; sub0 = '0;
    model_reset();
    repeat (2) @(negedge packet_clk);
    check_all("reset");
    reset_n = 1'b1;

    // Block 1: B on frame 0, C = 0xA5 repeating, directed word/parity frames.
    pat = 8'hA5;
    for (int k = 0; k < 192; k++) pat_block[k] = pat[k % 8];
    cs_cnt = 0;
    for (int k = 0; k < 192; k++) begin
      c0 = pat[k % 8];
      w0 = 24'($urandom()); w1 = 24'($urandom());
      if (k == 0 || k == 5) begin w0 = 24'h123456; w1 = 24'hABCDEF; end
      send(mk_hdr(0, 1, k == 0, 0),
           mk_sub(w0, w1, rnd_vu(c0), rnd_vu(c0), k == 5, 0));
      if (k == 0) begin
        check("dir_locked", 192'(locked), 192'(1));
        check("dir_sample_l", 192'(sample_l), 192'(24'h123456));
        check("dir_sample_r", 192'(sample_r), 192'(24'hABCDEF));
        check("dir_parity_ok", 192'(parity_error), 192'(2'b00));
      end
      if (k == 5) begin
        check("dir_parity_p0", 192'(parity_error), 192'(2'b01));
        check("dir_parity_locked", 192'(locked), 192'(1));
        check("dir_parity_index", 192'(frame_index), 192'(5));
      end
    end
    check("dir_cs_once", 192'(cs_cnt), 192'(1));
    check("dir_cs_pattern", channel_status_l, pat_block);

    // Block 2: early B at frame 100 restarts the block.
    cs_cnt = 0;
    for (int k = 0; k <= 100; k++) begin
      c0 = 1'($urandom());
      send(mk_hdr(0, 1, k == 0 || k == 100, 0),
           mk_sub(24'($urandom()), 24'($urandom()), rnd_vu(c0), rnd_vu(c0), 0, 0));
    end
    check("dir_early_b_sync", 192'(sync_error), 192'(1));
    check("dir_early_b_index", 192'(frame_index), 192'(0));
    for (int k = 1; k < 192; k++) begin
      c0 = 1'($urandom());
      send(mk_hdr(0, 1, 0, 0),
           mk_sub(24'($urandom()), 24'($urandom()), rnd_vu(c0), rnd_vu(c0), 0, 0));
    end
    check("dir_restart_cs_once", 192'(cs_cnt), 192'(1));

    // Frame 192 without B: framing lost, stays unlocked until the next B.
    send(mk_hdr(0, 1, 0, 0), mk_sub(24'h1, 24'h2, 3'b000, 3'b000, 0, 0));
    check("dir_loss_sync", 192'(sync_error), 192'(1));
    check("dir_loss_locked", 192'(locked), 192'(0));
    for (int k = 0; k < 4; k++)
      send(mk_hdr(0, 1, 0, 0), mk_sub(24'($urandom()), 24'($urandom()), 3'b100, 3'b100, 0, 0));
    check("dir_unlocked_hold", 192'(locked), 192'(0));

    // Layout 1, sample_present 0, then flat with B.
    send(mk_hdr(1, 1, 1, 0), mk_sub(24'h777777, 24'h888888, 3'b111, 3'b111, 0, 0));
    check("dir_layout_unsup", 192'(unsupported), 192'(1));
    check("dir_layout_nosv", 192'(sample_valid), 192'(0));
    send(mk_hdr(0, 0, 1, 0), mk_sub(24'h777777, 24'h888888, 3'b111, 3'b111, 0, 0));
    check("dir_absent_nolock", 192'(locked), 192'(0));
    send(mk_hdr(0, 1, 1, 1), mk_sub(24'h777777, 24'h888888, 3'b111, 3'b111, 1, 1));
    check("dir_flat_l", 192'(sample_l), 192'(0));
    check("dir_flat_par", 192'(parity_error), 192'(0));
    check("dir_flat_locked", 192'(locked), 192'(1));

    // Randomised traffic with a mid-block reset.
    for (int it = 0; it < 2500; it++) begin
      logic [15:0] hdr;
      if (it == 1200) do_reset();
      np = m_locked ? m_pos + 1 : 0;
      if (m_locked && m_pos == 191) b = ($urandom_range(0, 99) != 0);
      else if (m_locked)            b = ($urandom_range(0, 299) == 0);
      else                          b = ($urandom_range(0, 3) == 0);
      c0 = 1'($urandom());
      c1 = c0;
      if (np >= 20 && np <= 23) c1 = 1'($urandom());
      if ($urandom_range(0, 999) == 0) c1 = ~c1;
      hdr = mk_hdr($urandom_range(0, 15) == 0, $urandom_range(0, 15) != 0, b,
                   $urandom_range(0, 15) == 0);
      hdr = hdr | {3'b000, 1'b0, 3'($urandom()), 1'b0, 3'($urandom()), 1'b0, 3'($urandom()), 1'b0};
      send(hdr, mk_sub(24'($urandom()), 24'($urandom()), rnd_vu(c0), rnd_vu(c1),
                       $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
